// File: rtl/psr_stack_unit_if.sv
// Request/status bundle for psr_stack_unit.
// The master side (the control FSM and the branch logic) drives the event strobes
// and reads back the PSR state. The slave side is the PSR unit.
interface psr_stack_unit_if #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int PRIO_W      = 3
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                cc_en;
    logic [DATA_W-1:0]   result;
    logic                ld_psr;
    logic [15:0]         psr_in;
    logic                int_entry;
    logic [PRIO_W-1:0]   int_prio;
    logic                rti;

    logic [15:0]         psr;
    logic [2:0]          nzp;
    logic                supervisor;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_full;
    logic                stack_empty;
    logic                err_ovf;
    logic                err_unf;
    logic                priv_viol;

    modport master (
        output cc_en, result, ld_psr, psr_in, int_entry, int_prio, rti,
        input  psr, nzp, supervisor, depth, stack_full, stack_empty,
               err_ovf, err_unf, priv_viol
    );

    modport slave (
        input  cc_en, result, ld_psr, psr_in, int_entry, int_prio, rti,
        output psr, nzp, supervisor, depth, stack_full, stack_empty,
               err_ovf, err_unf, priv_viol
    );
endinterface

// File: rtl/psr_stack_unit.sv
// LC-3 processor status register with a LIFO shadow stack.
// Holds NZP, privilege and priority; interrupt entry pushes the current PSR
// and RTI pops it back. Request priority: int_entry > rti > ld_psr > cc_en.
// Optional feature: define PSR_PRIV_CHECK_EN to refuse rti/ld_psr in user mode
// (priv = 1) and flag it on priv_viol; without it priv_viol stays 0.
module psr_stack_unit #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int PRIO_W      = 3
) (
    input logic             clk,
    input logic             rst,
    psr_stack_unit_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    // Only the meaningful PSR fields are saved; the zero bits are rebuilt on read.
    localparam int ENT_W   = 1 + PRIO_W + 3;

    logic               priv;
    logic [PRIO_W-1:0]  prio;
    logic [2:0]         nzp;
    logic [DEPTH_W-1:0] depth;
    logic               err_ovf_q;
    logic               err_unf_q;
    logic               priv_viol_q;

    logic [ENT_W-1:0]   stack_mem [STACK_DEPTH];

    logic               full;
    logic               empty;
    logic               priv_block;
    logic               push_en;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic [ENT_W-1:0]   pop_entry;
    logic [2:0]         cc_code;
    logic               unused_psr_in;

    assign full      = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty     = (depth == '0);
    assign push_en   = bus.int_entry && !full;
    assign push_idx  = IDX_W'(depth);
    assign pop_idx   = IDX_W'(depth - 1'b1);
    assign pop_entry = stack_mem[pop_idx];

    // Only bits 15, 10:8 and 2:0 of psr_in carry meaning.
    assign unused_psr_in = ^bus.psr_in;

`ifdef PSR_PRIV_CHECK_EN
    assign priv_block = priv;
`else
    assign priv_block = 1'b0;
`endif

    // Condition code for the current execute-stage result; exactly one bit set.
    always_comb begin
        cc_code = 3'b001;
        if (bus.result == '0)
            cc_code = 3'b010;
        else if (bus.result[DATA_W-1])
            cc_code = 3'b100;
    end

    // Shadow stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_en)
            stack_mem[push_idx] <= {priv, prio, nzp};
    end

    // PSR state, depth and one-cycle error pulses, arbitrated by request priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            priv        <= 1'b0;
            prio        <= '0;
            nzp         <= 3'b000;
            depth       <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            priv_viol_q <= 1'b0;
        end else begin
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            priv_viol_q <= 1'b0;
            if (bus.int_entry) begin
                if (full) begin
                    err_ovf_q <= 1'b1;
                end else begin
                    priv  <= 1'b0;
                    prio  <= bus.int_prio;
                    nzp   <= 3'b010;
                    depth <= depth + 1'b1;
                end
            end else if (bus.rti) begin
                if (priv_block) begin
                    priv_viol_q <= 1'b1;
                end else if (empty) begin
                    err_unf_q <= 1'b1;
                end else begin
                    priv  <= pop_entry[ENT_W-1];
                    prio  <= pop_entry[3 +: PRIO_W];
                    nzp   <= pop_entry[2:0];
                    depth <= depth - 1'b1;
                end
            end else if (bus.ld_psr) begin
                if (priv_block) begin
                    priv_viol_q <= 1'b1;
                end else begin
                    priv <= bus.psr_in[15];
                    prio <= bus.psr_in[8 +: PRIO_W];
                    nzp  <= bus.psr_in[2:0];
                end
            end else if (bus.cc_en) begin
                nzp <= cc_code;
            end
        end
    end

    assign bus.psr         = {priv, 4'b0000, 3'(prio), 5'b00000, nzp};
    assign bus.nzp         = nzp;
    assign bus.supervisor  = ~priv;
    assign bus.depth       = depth;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_unf     = err_unf_q;
    assign bus.priv_viol   = priv_viol_q;
endmodule

// File: tb/tb_psr_stack_unit.sv
// Scoreboard bench for psr_stack_unit: the driver pushes the hand-computed
// expected output state for each request; the monitor pops and compares one
// entry per clock, one time unit after the rising edge.
module tb_psr_stack_unit;
    localparam bit PCHK =
`ifdef PSR_PRIV_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        string       tag;
        logic [28:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;
    exp_t sb_q[$];

    psr_stack_unit_if #(.DATA_W(16), .STACK_DEPTH(4), .PRIO_W(3)) bus ();

    psr_stack_unit #(.DATA_W(16), .STACK_DEPTH(4), .PRIO_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] mk(logic [15:0] p, logic [2:0] d,
                                       logic eo, logic eu, logic pv);
        return {p, p[2:0], ~p[15], d, (d == 3'd4), (d == 3'd0), eo, eu, pv};
    endfunction

    function automatic logic [28:0] actual();
        return {bus.psr, bus.nzp, bus.supervisor, bus.depth, bus.stack_full,
                bus.stack_empty, bus.err_ovf, bus.err_unf, bus.priv_viol};
    endfunction

    task automatic check(string tag, logic [28:0] got, logic [28:0] want);
        total++;
        if (got === want)
            passed++;
        else
            $display("FAIL %s: got psr=%h nzp=%b sup=%b depth=%0d full=%b empty=%b ovf=%b unf=%b pv=%b, required psr=%h nzp=%b sup=%b depth=%0d full=%b empty=%b ovf=%b unf=%b pv=%b",
                     tag, got[28:13], got[12:10], got[9], got[8:6], got[5], got[4], got[3], got[2], got[1],
                     want[28:13], want[12:10], want[9], want[8:6], want[5], want[4], want[3], want[2], want[1]);
    endtask

    task automatic clear_strobes();
        bus.cc_en     = 1'b0;
        bus.result    = '0;
        bus.ld_psr    = 1'b0;
        bus.psr_in    = '0;
        bus.int_entry = 1'b0;
        bus.int_prio  = '0;
        bus.rti       = 1'b0;
    endtask

    task automatic cyc(string tag, logic c, logic [15:0] res, logic l, logic [15:0] pin,
                       logic ie, logic [2:0] ip, logic r,
                       logic [15:0] ep, logic [2:0] ed, logic eo, logic eu, logic pv);
        exp_t e;
        @(negedge clk);
        bus.cc_en     = c;
        bus.result    = res;
        bus.ld_psr    = l;
        bus.psr_in    = pin;
        bus.int_entry = ie;
        bus.int_prio  = ip;
        bus.rti       = r;
        e.tag = tag;
        e.vec = mk(ep, ed, eo, eu, pv);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        clear_strobes();
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_strobes();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: one expected state per clock while the scoreboard holds entries.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.tag, actual(), e.vec);
            end
        end
    end

    initial begin
        clear_strobes();
        rst = 1'b0;
        #12;
        check("reset_state", actual(), mk(16'h0000, 3'd0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        // Condition codes
        cyc("cc_zero", 1, 16'h0000, 0, 16'h0, 0, 3'd0, 0, 16'h0002, 3'd0, 0, 0, 0);
        cyc("cc_neg",  1, 16'h8001, 0, 16'h0, 0, 3'd0, 0, 16'h0004, 3'd0, 0, 0, 0);
        cyc("cc_pos",  1, 16'h7FFF, 0, 16'h0, 0, 3'd0, 0, 16'h0001, 3'd0, 0, 0, 0);

        // Load, push, pop
        cyc("ld_user",   0, 16'h0, 1, 16'h8001, 0, 3'd0, 0, 16'h8001, 3'd0, 0, 0, 0);
        cyc("int_prio4", 0, 16'h0, 0, 16'h0,    1, 3'd4, 0, 16'h0402, 3'd1, 0, 0, 0);
        cyc("rti_back",  0, 16'h0, 0, 16'h0,    0, 3'd0, 1, 16'h8001, 3'd0, 0, 0, 0);

        // User mode with one saved entry
        cyc("int_prio2", 0, 16'h0, 0, 16'h0,    1, 3'd2, 0, 16'h0202, 3'd1, 0, 0, 0);
        cyc("ld_user2",  0, 16'h0, 1, 16'h8001, 0, 3'd0, 0, 16'h8001, 3'd1, 0, 0, 0);
        cyc("rti_user",  0, 16'h0, 0, 16'h0,    0, 3'd0, 1, 16'h8001, PCHK ? 3'd1 : 3'd0, 0, 0, PCHK);
        cyc("ld_user3",  0, 16'h0, 1, 16'h0000, 0, 3'd0, 0, PCHK ? 16'h8001 : 16'h0000,
            PCHK ? 3'd1 : 3'd0, 0, 0, PCHK);
        drain();
        do_reset();

        // Fill, overflow, drain in reverse, underflow twice
        cyc("push1", 0, 16'h0, 0, 16'h0, 1, 3'd1, 0, 16'h0102, 3'd1, 0, 0, 0);
        cyc("push2", 0, 16'h0, 0, 16'h0, 1, 3'd2, 0, 16'h0202, 3'd2, 0, 0, 0);
        cyc("push3", 0, 16'h0, 0, 16'h0, 1, 3'd3, 0, 16'h0302, 3'd3, 0, 0, 0);
        cyc("push4", 0, 16'h0, 0, 16'h0, 1, 3'd4, 0, 16'h0402, 3'd4, 0, 0, 0);
        cyc("push5_ovf", 0, 16'h0, 0, 16'h0, 1, 3'd5, 0, 16'h0402, 3'd4, 1, 0, 0);
        cyc("pop1", 0, 16'h0, 0, 16'h0, 0, 3'd0, 1, 16'h0302, 3'd3, 0, 0, 0);
        cyc("pop2", 0, 16'h0, 0, 16'h0, 0, 3'd0, 1, 16'h0202, 3'd2, 0, 0, 0);
        cyc("pop3", 0, 16'h0, 0, 16'h0, 0, 3'd0, 1, 16'h0102, 3'd1, 0, 0, 0);
        cyc("pop4", 0, 16'h0, 0, 16'h0, 0, 3'd0, 1, 16'h0000, 3'd0, 0, 0, 0);
        cyc("pop5_unf", 0, 16'h0, 0, 16'h0, 0, 3'd0, 1, 16'h0000, 3'd0, 0, 1, 0);
        cyc("pop6_unf", 0, 16'h0, 0, 16'h0, 0, 3'd0, 1, 16'h0000, 3'd0, 0, 1, 0);
        cyc("idle_clr", 0, 16'h0, 0, 16'h0, 0, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 0);

        // Request priority
        cyc("prio_int_wins", 1, 16'hFFFF, 0, 16'h0,    1, 3'd6, 1, 16'h0602, 3'd1, 0, 0, 0);
        cyc("prio_ld_vs_cc", 1, 16'h0000, 1, 16'h0001, 0, 3'd0, 0, 16'h0001, 3'd1, 0, 0, 0);
        cyc("prio_rti_vs_ld", 0, 16'h0,   1, 16'h8004, 0, 3'd0, 1, 16'h0000, 3'd0, 0, 0, 0);

        // Build depth 3, then async reset between edges
        cyc("d3_push1", 0, 16'h0, 0, 16'h0, 1, 3'd1, 0, 16'h0102, 3'd1, 0, 0, 0);
        cyc("d3_push2", 0, 16'h0, 0, 16'h0, 1, 3'd2, 0, 16'h0202, 3'd2, 0, 0, 0);
        cyc("d3_push3", 0, 16'h0, 0, 16'h0, 1, 3'd3, 0, 16'h0302, 3'd3, 0, 0, 0);
        drain();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", actual(), mk(16'h0000, 3'd0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        cyc("post_reset_cc", 1, 16'hFFFF, 0, 16'h0, 0, 3'd0, 0, 16'h0004, 3'd0, 0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/psr_stack_unit.md
# psr_stack_unit

Parametrised processor status register for the LC-3 datapath. It holds the NZP condition codes, privilege bit and priority level, plus a LIFO shadow stack that saves and restores the full PSR on interrupt entry and RTI. It replaces the standalone NZP register. It sits beside the execute stage: the control FSM drives the event strobes, and branch logic reads `nzp`.

## Interface

Parameters:
- `DATA_W`, 16: width of the execute-stage result used for condition-code evaluation (≥2).
- `STACK_DEPTH`, 4: number of saved PSR entries (≥1).
- `PRIO_W`, 3: priority-level width (1..3, packed into `psr[10:8]`, zero-extended).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cc_en`  in  1  update NZP from `result` this cycle.
- `result`  in  `DATA_W`  execute-stage result.
- `ld_psr`  in  1  load full PSR from `psr_in`.
- `psr_in`  in  16  PSR load value (bits 15, 10:8, 2:0 used; others ignored).
- `int_entry`  in  1  interrupt/exception entry: push current PSR, enter supervisor.
- `int_prio`  in  `PRIO_W`  priority level installed on `int_entry`.
- `rti`  in  1  return from interrupt: pop saved PSR.
- `psr`  out  16  `{priv, 4'b0, prio(3), 5'b0, nzp(3)}`; unused bits always 0.
- `nzp`  out  3  condition codes {N,Z,P}.
- `supervisor`  out  1  high when `priv`==0.
- `depth`  out  `$clog2(STACK_DEPTH+1)`  number of saved entries.
- `stack_full`, `stack_empty`  out  1  depth==`STACK_DEPTH` / depth==0.
- `err_ovf`, `err_unf`, `priv_viol`  out  1  one-cycle registered error pulses.

## Operation

- Reset (async, `rst`=0): `priv`=0, `prio`=0, `nzp`=3'b000, `depth`=0, all error pulses 0, stack contents don't-care. `psr`=16'h0000, `stack_empty`=1.
- Condition codes: `result`==0 → 3'b010; `result[DATA_W-1]`=1 → 3'b100; otherwise 3'b001. Exactly one bit is set after any CC write.
- Request priority when several strobes are high in one cycle: `int_entry` > `rti` > `ld_psr` > `cc_en`. Only the winner acts; the losers are dropped silently.
- `int_entry`:
  - When not full: push the current 16-bit `psr`, then set `priv`=0, `prio`=`int_prio`, `nzp`=3'b010, `depth`+1.
  - When full: no state change, and `err_ovf` pulses.
- `rti`:
  - When not empty and permitted: pop the top entry into `priv`/`prio`/`nzp`, `depth`-1.
  - When empty: no state change, and `err_unf` pulses.
- `ld_psr` (when permitted): `priv`=`psr_in[15]`, `prio`=`psr_in[8+PRIO_W-1:8]`, `nzp`=`psr_in[2:0]`. The stack is untouched.
- `cc_en`: only `nzp` changes.
- The stack is strict LIFO. `depth` never wraps: it saturates by refusal at 0 and at `STACK_DEPTH`.

## Timing

- All updates are registered: a request sampled at edge k is visible on outputs after edge k. Latency is 1 cycle, with no combinational path from inputs to outputs.
- Error pulses are high for exactly the cycle following the offending request edge. Back-to-back faulty requests give back-to-back pulses.
- Push and pop never occur in the same cycle, because the priority rule forbids it.
- A reset assertion mid-sequence clears state immediately, without waiting for `clk`. Deassertion is synchronised externally.

## Configuration

- `PSR_PRIV_CHECK_EN` defined:
  - `rti` or `ld_psr` while `priv`=1 (user mode) is refused with no state change, and `priv_viol` pulses.
  - The privilege check takes precedence over the `err_unf` check.
- `PSR_PRIV_CHECK_EN` undefined:
  - `rti` and `ld_psr` act in any mode.
  - `priv_viol` is tied to 0.

## Test plan

- Reset, then `cc_en` with `result`=16'h0000, then 16'h8001, then 16'h7FFF → `nzp`=010, 100, 001 on successive cycles. Before the first write, `nzp`=000 and `psr`=16'h0000.
- `ld_psr` 16'h8001, then `int_entry` with `int_prio`=3'd4 → `psr`=16'h0402, `depth`=1; then `rti` → `psr`=16'h8001, `depth`=0, `stack_empty`=1.
- `STACK_DEPTH`=4: five `int_entry` with prio 1..5 → after the 4th, `stack_full`=1 and `psr[10:8]`=4. The 5th gives `err_ovf` for one cycle with `psr` unchanged. Then four `rti` restore in reverse order, and a 5th `rti` raises `err_unf`.
- Same cycle `int_entry`+`rti`+`cc_en` with `result`=16'hFFFF → only the push occurs: `nzp`=010, `depth`+1.
- With `PSR_PRIV_CHECK_EN`: user mode (`psr`=16'h8001) with one saved entry, then `rti` → `priv_viol`=1 for one cycle, `depth` unchanged. Without the macro, the same stimulus pops and `priv_viol` stays 0.
- Assert `rst`=0 mid-cycle with `depth`=3 → outputs clear immediately, before the next `clk` edge.
